// File: rtl/audio_decimator_fifo.sv
// Boxcar decimator (accumulate-and-dump) feeding a small FWFT FIFO toward the audio sink.
// Optional DC-block stage between decimator and FIFO: define AUDIO_DECIM_DC_BLOCK_EN.
module audio_decimator_fifo #(
    parameter int LOG2_DECIM      = 6,
    parameter int FIFO_LOG2_DEPTH = 2,
    parameter int DC_SHIFT        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_3MHz_en,
    input  logic [15:0] in,
    input  logic        mute,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  overflow_cnt
);
    localparam int ACC_W = 16 + LOG2_DECIM;
    localparam int DEPTH = 1 << FIFO_LOG2_DEPTH;
    localparam int PW    = FIFO_LOG2_DEPTH + 1;

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic [LOG2_DECIM-1:0] cnt;
    logic [15:0]           dec_sample;
    logic                  dec_valid;

    // The dump strobe folds the final input into the average, so no sample straddles windows.
    assign acc_sum = acc + ACC_W'(in);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            dec_sample <= '0;
            dec_valid  <= 1'b0;
        end else begin
            dec_valid <= 1'b0;
            if (clk_3MHz_en) begin
                cnt <= cnt + LOG2_DECIM'(1);
                if (cnt == '1) begin
                    dec_sample <= acc_sum[ACC_W-1:LOG2_DECIM];
                    acc        <= '0;
                    dec_valid  <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    logic        push_valid;
    logic [15:0] push_data;

`ifdef AUDIO_DECIM_DC_BLOCK_EN
    logic               s1_valid;
    logic               s1_mute;
    logic [15:0]        s1_sample;
    logic signed [18:0] x_cur;
    logic signed [18:0] y_cur;
    logic signed [18:0] x_prev;
    logic signed [18:0] y_prev;
    logic signed [15:0] y_sat;

    always_comb begin
        x_cur = $signed({3'b000, s1_sample}) - 19'sd32768;
        y_cur = x_cur - x_prev + y_prev - (y_prev >>> DC_SHIFT);
        if (y_cur > 19'sd32767)
            y_sat = 16'sh7FFF;
        else if (y_cur < -19'sd32768)
            y_sat = 16'sh8000;
        else
            y_sat = y_cur[15:0];
    end

    // Mute is captured with the decimated sample so the filter sees a consistent pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_mute    <= 1'b0;
            s1_sample  <= '0;
            x_prev     <= '0;
            y_prev     <= '0;
            push_valid <= 1'b0;
            push_data  <= '0;
        end else begin
            s1_valid   <= dec_valid;
            push_valid <= s1_valid;
            if (dec_valid) begin
                s1_mute   <= mute;
                s1_sample <= dec_sample;
            end
            if (s1_valid) begin
                if (s1_mute) begin
                    push_data <= '0;
                end else begin
                    push_data <= {~y_sat[15], y_sat[14:0]};
                    x_prev    <= x_cur;
                    y_prev    <= y_cur;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            push_valid <= 1'b0;
            push_data  <= '0;
        end else begin
            push_valid <= dec_valid;
            if (dec_valid)
                push_data <= mute ? 16'h0000 : dec_sample;
        end
    end
`endif

    // Sink handshake: a word transfers on any clk edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_data is stable while out_valid is held.
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          fifo_full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign out_valid = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign pop       = out_valid && out_ready;
    assign wr_en     = push_valid && (!fifo_full || pop);
    assign drop      = push_valid && fifo_full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr[PW-2:0]] : 16'h0000;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[PW-2:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_audio_decimator_fifo.sv
// Scoreboard bench for audio_decimator_fifo; expected samples are queued as windows are driven.
module tb_audio_decimator_fifo;
  logic        clk;
  logic        rst;
  logic        clk_3MHz_en;
  logic [15:0] in;
  logic        mute;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  overflow_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  int mx = 0;
  int my = 0;
  logic [7:0] exp_ovf = 8'd0;

`ifdef AUDIO_DECIM_DC_BLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  audio_decimator_fifo dut (
    .clk(clk), .rst(rst), .clk_3MHz_en(clk_3MHz_en), .in(in), .mute(mute),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow_cnt(overflow_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d samples still expected", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // scoreboard: compare every transfer against the queue head
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: out_data=%h popped with no sample expected", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL pop_data: out_data=%h expected %h", out_data, e);
        end
      end
    end
  end

  // reference model of the value pushed for one window average
  task automatic model(input logic [15:0] avg, input bit m, output logic [15:0] e);
`ifdef AUDIO_DECIM_DC_BLOCK_EN
    int x, y, ys;
    if (m) begin
      e = 16'h0000;
    end else begin
      x = int'(avg) - 32768;
      y = x - mx + my - (my >>> 8);
      mx = x;
      my = y;
      ys = (y > 32767) ? 32767 : ((y < -32768) ? -32768 : y);
      e = 16'(ys + 32768);
    end
`else
    e = m ? 16'h0000 : avg;
`endif
  endtask

  // driver tasks (entered and left 1ns after a rising edge)
  task automatic strobe(input logic [15:0] v);
    clk_3MHz_en = 1'b1;
    in = v;
    @(posedge clk); #1;
    clk_3MHz_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive_window(input int kind, input logic [15:0] base);
    for (int i = 0; i < 64; i++)
      strobe(kind == 1 ? base + 16'(i) : base);
  endtask

  task automatic run_window(input int kind, input logic [15:0] base, input bit keep, input bit m);
    int sum;
    logic [15:0] e;
    sum = 0;
    for (int i = 0; i < 64; i++)
      sum += (kind == 1) ? int'(base) + i : int'(base);
    model(16'(sum >> 6), m, e);
    if (keep) exp_q.push_back(e);
    drive_window(kind, base);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mx = 0;
    my = 0;
    exp_ovf = 8'd0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && out_valid === 1'b0) break;
    end
    vectors++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: out_valid=%b pending=%0d expected out_valid=0 pending=0",
               name, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    clk_3MHz_en = 1'b0; in = 16'h0; mute = 1'b0; out_ready = 1'b0;
    do_reset();
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_data !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", out_data); end
    if (overflow_cnt !== 8'h0) begin miscompares++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_constant_latency();
    out_ready = 1'b1;
    run_window(0, 16'h1234, 1'b1, 1'b0);
    // now just after edge T+1
    for (int k = 1; k < LAT; k++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early: out_valid=%b at T+%0d expected 0", out_valid, k);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_arrive: out_valid=%b at T+%0d expected 1", out_valid, LAT);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pop: out_valid=%b one cycle after pop expected 0", out_valid);
    end
    drain("constant");
  endtask

  task automatic test_ramp();
    out_ready = 1'b1;
    run_window(1, 16'h0000, 1'b1, 1'b0);
    run_window(0, 16'hFFFF, 1'b1, 1'b0);
    drain("ramp");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int w = 1; w <= 6; w++)
      run_window(0, 16'(w * 256), w <= 4, 1'b0);
    exp_ovf = exp_ovf + 8'd2;
    repeat (LAT) @(posedge clk);
    #1;
    vectors += 3;
    if (overflow_cnt !== exp_ovf) begin miscompares++; $display("FAIL overflow_cnt: got %0d expected %0d", overflow_cnt, exp_ovf); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL overflow_valid: got %b expected 1", out_valid); end
    if (out_data !== exp_q[0]) begin miscompares++; $display("FAIL overflow_head: got %h expected %h", out_data, exp_q[0]); end
    drain("overflow");
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int w = 0; w < 4; w++)
      run_window(0, 16'h1000 + 16'(w * 16'h0111), 1'b1, 1'b0);
    run_window(0, 16'h5A5A, 1'b1, 1'b0);
    // hold ready for exactly the edge that also writes the fifth sample
    repeat (LAT - 2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 2;
    if (overflow_cnt !== exp_ovf) begin miscompares++; $display("FAIL fullpp_ovf: got %0d expected %0d", overflow_cnt, exp_ovf); end
    if (exp_q.size() != 4) begin miscompares++; $display("FAIL fullpp_pending: got %0d expected 4", exp_q.size()); end
    drain("fullpp");
  endtask

  task automatic test_mute();
    out_ready = 1'b1;
    mute = 1'b1;
    run_window(0, 16'h7FFF, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    mute = 1'b0;
    run_window(0, 16'h4321, 1'b1, 1'b0);
    drain("mute");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++)
      strobe(16'hFFFF);
    do_reset();
    rst = 1'b0;
    vectors++;
    if (overflow_cnt !== 8'h0) begin miscompares++; $display("FAIL midreset_ovf: got %0d expected 0", overflow_cnt); end
    out_ready = 1'b1;
    run_window(0, 16'h0010, 1'b1, 1'b0);
    drain("midreset");
  endtask

`ifdef AUDIO_DECIM_DC_BLOCK_EN
  task automatic test_dc_block();
    logic [15:0] consts[3];
    consts[0] = 16'h9000; consts[1] = 16'h8FF0; consts[2] = 16'h8FE1;
    out_ready = 1'b0;
    do_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(consts[w]);
      drive_window(0, 16'h9000);
    end
    drain("dcblock");
  endtask
`endif

  initial begin
    test_reset();
    test_constant_latency();
    test_ramp();
    test_overflow();
    test_full_push_pop();
    test_mute();
    test_reset_mid();
`ifdef AUDIO_DECIM_DC_BLOCK_EN
    test_dc_block();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
